// File: rtl/pipelined_mem_top.sv
// Byte-maskable word memory with a LATENCY-cycle read pipeline and an
// in-order response FIFO. Read acceptance is throttled so that reads in the
// pipeline plus buffered responses never exceed RESP_DEPTH.
module pipelined_mem_top #(
  parameter int INIT_MEM   = 0,   // nonzero: preload requested
  parameter int DataWidth  = 32,  // multiple of 8
  parameter int Address    = 8,   // word address width
  parameter int LATENCY    = 1,   // 1..4
  parameter int RESP_DEPTH = 4    // >= LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request,
  input  logic                   we_re,
  input  logic [DataWidth/8-1:0] mask,
  input  logic [Address-1:0]     address,
  input  logic [DataWidth-1:0]   data_in,
  output logic                   req_ready,
  output logic                   valid,
  input  logic                   resp_ready,
  output logic [DataWidth-1:0]   data_out
);

  localparam int Lanes = DataWidth / 8;
  localparam int Depth = 2 ** Address;
  localparam int CntW  = $clog2(RESP_DEPTH + 1);
  localparam int PtrW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] fifo_mem [RESP_DEPTH];

  logic                 accept, rd_acc, wr_acc, pop;
  logic                 push_vld;
  logic [DataWidth-1:0] push_dat;
  logic [DataWidth-1:0] rd_word;
  logic [CntW-1:0]      outstanding, fifo_cnt;
  logic [PtrW-1:0]      wr_ptr, rd_ptr;

  // Pointers wrap at RESP_DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // req_ready depends only on the registered outstanding count.
  assign req_ready = (outstanding < CntW'(RESP_DEPTH));
  assign accept    = request && req_ready;
  assign rd_acc    = accept && !we_re;
  assign wr_acc    = accept && we_re;
  assign valid     = (fifo_cnt != '0);
  assign data_out  = fifo_mem[rd_ptr];
  assign pop       = valid && resp_ready;
  assign rd_word   = mem[address];

  // Byte-lane masked write on an accepted write request.
  // NOTE: storage arrays carry no reset; contents survive rst by design and a
  // reset term would turn the array into a huge bank of flops.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < Lanes; b++) begin
        if (mask[b]) mem[address][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  // Read pipeline: sample at the accept edge, then LATENCY-1 register stages.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld = rd_acc;
      assign push_dat = rd_word;
    end else begin : g_pipe
      logic [LATENCY-2:0]   st_vld;
      logic [DataWidth-1:0] st_dat [LATENCY-1];

      // Stage valid bits; cleared by reset so in-flight reads are discarded.
      // NOTE: sequential state uses <= so every stage sees the pre-edge value
      // of its predecessor, giving a true shift regardless of statement order.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          st_vld <= '0;
        end else begin
          st_vld[0] <= rd_acc;
          for (int i = 1; i < LATENCY - 1; i++) st_vld[i] <= st_vld[i-1];
        end
      end

      // Stage data shifts freely; only the valid bits give it meaning.
      always_ff @(posedge clk) begin
        st_dat[0] <= rd_word;
        for (int i = 1; i < LATENCY - 1; i++) st_dat[i] <= st_dat[i-1];
      end

      assign push_vld = st_vld[LATENCY-2];
      assign push_dat = st_dat[LATENCY-2];
    end
  endgenerate

  // Outstanding count, FIFO occupancy and FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      case ({push_vld, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Response FIFO storage; occupancy never exceeds RESP_DEPTH.
  always_ff @(posedge clk) begin
    if (push_vld) fifo_mem[wr_ptr] <= push_dat;
  end

endmodule
